// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, optional glitch filter,
// mode-selected edge pulses, sticky status with clear, irq summary and saturating event count.
module multi_edge_detector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 0,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clr,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     edge_pulse,
    output logic [WIDTH-1:0]     status,
    output logic                 irq,
    output logic [CNT_W-1:0]     evt_cnt
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_edge_pulse;
    logic [WIDTH-1:0] r_status;
    logic [CNT_W-1:0] r_evt_cnt;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_level_next;
    logic [WIDTH-1:0] w_chg;
    logic [WIDTH-1:0] w_pulse_next;
    logic [WIDTH-1:0] w_status_next;
    logic [PC_W-1:0]  w_pop;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= din[gi];
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_s[gi] = r_sync[SYNC_STAGES-1];

            if (FILT_CYCLES == 0) begin : g_nofilt
                assign w_level_next[gi] = w_s[gi];
            end else begin : g_filt
                localparam int FC_W = $clog2(FILT_CYCLES + 1);
                localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);
                logic [FC_W-1:0] r_fc;

                // A new level is only accepted once it has differed for FILT_CYCLES cycles in a row.
                assign w_level_next[gi] = ((w_s[gi] != r_level[gi]) && (r_fc == FC_LAST))
                                          ? w_s[gi] : r_level[gi];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_fc <= '0;
                    end else if (w_s[gi] == r_level[gi]) begin
                        r_fc <= '0;
                    end else if (r_fc == FC_LAST) begin
                        r_fc <= '0;
                    end else begin
                        r_fc <= r_fc + 1'b1;
                    end
                end
            end

            assign w_chg[gi]        = w_level_next[gi] ^ r_level[gi];
            assign w_pulse_next[gi] = (w_chg[gi] &  w_level_next[gi] & mode[2*gi])
                                    | (w_chg[gi] & ~w_level_next[gi] & mode[2*gi+1]);
            // Set beats a simultaneous clear.
            assign w_status_next[gi] = w_pulse_next[gi] | (r_status[gi] & ~clr[gi]);
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_pop = w_pop + PC_W'(w_pulse_next[k]);
        end
    end

    // Clearing reloads with this cycle's events so none are dropped.
    always_comb begin
        w_sum      = (cnt_clr ? '0 : SUM_W'(r_evt_cnt)) + SUM_W'(w_pop);
        w_cnt_next = (w_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level      <= '0;
            r_edge_pulse <= '0;
            r_status     <= '0;
            r_evt_cnt    <= '0;
        end else begin
            r_level      <= w_level_next;
            r_edge_pulse <= w_pulse_next;
            r_status     <= w_status_next;
            r_evt_cnt    <= w_cnt_next;
        end
    end

    assign level      = r_level;
    assign edge_pulse = r_edge_pulse;
    assign status     = r_status;
    assign irq        = |r_status;
    assign evt_cnt    = r_evt_cnt;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: default, filtered (FILT_CYCLES=4) and narrow-counter (CNT_W=4) instances.
module tb_multi_edge_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: defaults
    logic [7:0]  din_a = '0, clr_a = '0;
    logic [15:0] mode_a = 16'hFFFF;
    logic        cnt_clr_a = 1'b0;
    logic [7:0]  level_a, edge_a, status_a, evt_a;
    logic        irq_a;

    // Instance B: glitch filter
    logic [7:0]  din_b = '0, clr_b = '0;
    logic [15:0] mode_b = 16'hFFFF;
    logic        cnt_clr_b = 1'b0;
    logic [7:0]  level_b, edge_b, status_b, evt_b;
    logic        irq_b;

    // Instance C: 4-bit counter
    logic [7:0]  din_c = '0, clr_c = '0;
    logic [15:0] mode_c = 16'hFFFF;
    logic        cnt_clr_c = 1'b0;
    logic [7:0]  level_c, edge_c, status_c;
    logic [3:0]  evt_c;
    logic        irq_c;

    multi_edge_detector u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .mode(mode_a), .clr(clr_a), .cnt_clr(cnt_clr_a),
        .level(level_a), .edge_pulse(edge_a), .status(status_a), .irq(irq_a), .evt_cnt(evt_a)
    );

    multi_edge_detector #(.FILT_CYCLES(4)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .mode(mode_b), .clr(clr_b), .cnt_clr(cnt_clr_b),
        .level(level_b), .edge_pulse(edge_b), .status(status_b), .irq(irq_b), .evt_cnt(evt_b)
    );

    multi_edge_detector #(.CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .din(din_c), .mode(mode_c), .clr(clr_c), .cnt_clr(cnt_clr_c),
        .level(level_c), .edge_pulse(edge_c), .status(status_c), .irq(irq_c), .evt_cnt(evt_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        check_val("rst_level_a", 32'(level_a), 32'h0);
        check_val("rst_status_a", 32'(status_a), 32'h0);
        check_val("rst_evt_a", 32'(evt_a), 32'h0);
        rst = 1'b0;
        tick(2);

        // Either-edge on ch0, 3-cycle latency, single-cycle pulse
        din_a = 8'h01;
        tick(2);
        check_val("a_rise_early", 32'(edge_a), 32'h0);
        tick(1);
        check_val("a_rise_pulse", 32'(edge_a), 32'h01);
        check_val("a_rise_level", 32'(level_a), 32'h01);
        check_val("a_rise_evt", 32'(evt_a), 32'd1);
        tick(1);
        check_val("a_rise_end", 32'(edge_a), 32'h0);
        tick(6);
        din_a = 8'h00;
        tick(2);
        check_val("a_fall_early", 32'(edge_a), 32'h0);
        tick(1);
        check_val("a_fall_pulse", 32'(edge_a), 32'h01);
        tick(1);
        check_val("a_fall_end", 32'(edge_a), 32'h0);
        check_val("a_status", 32'(status_a), 32'h01);
        check_val("a_irq", 32'(irq_a), 32'h1);
        check_val("a_evt2", 32'(evt_a), 32'd2);

        // Per-channel modes: ch1 rise, ch2 fall, ch3 off
        mode_a = 16'hFF27;
        clr_a = 8'hFF;
        cnt_clr_a = 1'b1;
        tick(1);
        clr_a = 8'h00;
        cnt_clr_a = 1'b0;
        check_val("a_cleared_status", 32'(status_a), 32'h0);
        check_val("a_cleared_irq", 32'(irq_a), 32'h0);
        check_val("a_cleared_evt", 32'(evt_a), 32'd0);
        din_a = 8'h0E;
        tick(3);
        check_val("mode_rise_pulse", 32'(edge_a), 32'h02);
        check_val("mode_rise_level", 32'(level_a), 32'h0E);
        tick(3);
        din_a = 8'h00;
        tick(3);
        check_val("mode_fall_pulse", 32'(edge_a), 32'h04);
        check_val("mode_fall_level", 32'(level_a), 32'h00);
        tick(1);
        check_val("mode_evt", 32'(evt_a), 32'd2);
        check_val("mode_status", 32'(status_a), 32'h06);

        // Clear coinciding with a new set: set wins
        din_a = 8'h04;
        tick(3);
        check_val("clr_rise_nopulse", 32'(edge_a), 32'h0);
        tick(2);
        din_a = 8'h00;
        tick(2);
        clr_a = 8'h04;
        tick(1);
        clr_a = 8'h00;
        check_val("clr_same_pulse", 32'(edge_a), 32'h04);
        check_val("clr_same_status", 32'(status_a), 32'h06);
        tick(1);
        clr_a = 8'h06;
        tick(1);
        clr_a = 8'h00;
        check_val("clr_alone_status", 32'(status_a), 32'h0);
        check_val("clr_alone_irq", 32'(irq_a), 32'h0);
        check_val("clr_evt", 32'(evt_a), 32'd3);

        // Filter: 3-cycle glitch rejected
        din_b = 8'h01;
        tick(3);
        din_b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_val($sformatf("filt_glitch_pulse%0d", i), 32'(edge_b), 32'h0);
            check_val($sformatf("filt_glitch_level%0d", i), 32'(level_b), 32'h0);
        end
        // Stable high accepted after 6 cycles
        din_b = 8'h01;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check_val($sformatf("filt_wait%0d", i), 32'(edge_b), 32'h0);
        end
        tick(1);
        check_val("filt_pulse", 32'(edge_b), 32'h01);
        check_val("filt_level", 32'(level_b), 32'h01);
        tick(1);
        check_val("filt_pulse_end", 32'(edge_b), 32'h0);

        // Saturating 4-bit counter with 8 simultaneous channels
        din_c = 8'hFF;
        tick(3);
        check_val("cnt_pulse_all", 32'(edge_c), 32'hFF);
        check_val("cnt_first", 32'(evt_c), 32'd8);
        tick(1);
        din_c = 8'h00;
        tick(3);
        check_val("cnt_sat", 32'(evt_c), 32'd15);
        tick(1);
        din_c = 8'hFF;
        tick(3);
        check_val("cnt_hold", 32'(evt_c), 32'd15);
        tick(1);
        din_c = 8'h00;
        tick(2);
        cnt_clr_c = 1'b1;
        tick(1);
        cnt_clr_c = 1'b0;
        check_val("cnt_clr_with_pulse", 32'(evt_c), 32'd8);
        tick(1);
        check_val("cnt_after_clr", 32'(evt_c), 32'd8);

        // Asynchronous reset mid-filter and mid-count
        din_b = 8'h00;
        tick(3);
        din_a = 8'h01;
        rst = 1'b1;
        #1;
        check_val("arst_level_a", 32'(level_a), 32'h0);
        check_val("arst_edge_a", 32'(edge_a), 32'h0);
        check_val("arst_evt_a", 32'(evt_a), 32'h0);
        check_val("arst_level_b", 32'(level_b), 32'h0);
        check_val("arst_status_b", 32'(status_b), 32'h0);
        check_val("arst_irq_b", 32'(irq_b), 32'h0);
        check_val("arst_evt_c", 32'(evt_c), 32'h0);
        check_val("arst_status_c", 32'(status_c), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check_val("rel_early", 32'(edge_a), 32'h0);
        tick(1);
        check_val("rel_pulse", 32'(edge_a), 32'h01);
        check_val("rel_level", 32'(level_a), 32'h01);
        tick(1);
        check_val("rel_pulse_end", 32'(edge_a), 32'h0);
        check_val("rel_evt", 32'(evt_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
